// File: rtl/data_sram_resp_if.sv
// Data SRAM port bundle between the core's data port and the memory-side responder.
// The master drives the request; the slave returns registered read data.
interface data_sram_resp_if;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output en, output wen, output addr, output wdata, input rdata);
   modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/data_sram_resp.sv
// Memory-side responder for the core's data SRAM port: word-addressed synchronous RAM
// plus a config-register window (scratch, LED, switch, timer, compare, IRQ status).
module data_sram_resp #(
   parameter int          RAM_AW    = 12,
   parameter logic [31:0] CONF_BASE = 32'hBFAF_0000,
   parameter int          LED_W     = 16
) (
   input  logic             clk,
   input  logic             resetn,
   data_sram_resp_if.slave  data_sram,
   output logic [LED_W-1:0] led,
   input  logic [7:0]       switch,
   output logic             timer_irq
);

   localparam int DEPTH = 1 << RAM_AW;

   typedef enum logic [13:0] {
      REG_SCRATCH = 14'd0,
      REG_LED     = 14'd1,
      REG_SWITCH  = 14'd2,
      REG_TIMER   = 14'd3,
      REG_COMPARE = 14'd4,
      REG_IRQ     = 14'd5
   } reg_word_e;

   function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
      lane_merge = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) lane_merge[8*i +: 8] = new_word[8*i +: 8];
      end
   endfunction

   logic              conf_hit;
   logic              rd;
   logic              wr;
   logic              conf_wr;
   logic              ram_we;
   logic [13:0]       reg_word;
   logic [RAM_AW-1:0] ram_idx;

   logic [31:0]       mem [DEPTH];
   logic [31:0]       scratch;
   logic [LED_W-1:0]  led_q;
   logic [31:0]       led_ext;
   logic [31:0]       led_merged;
   logic [7:0]        switch_meta;
   logic [7:0]        switch_sync;
   logic [31:0]       timer;
   logic [31:0]       compare;
   logic              irq;
   logic              irq_clr;
   logic [31:0]       conf_rdata;
   logic              unused_addr;

   assign conf_hit    = (data_sram.addr[31:16] == CONF_BASE[31:16]);
   assign rd          = data_sram.en && (data_sram.wen == 4'b0000);
   assign wr          = data_sram.en && (data_sram.wen != 4'b0000);
   assign conf_wr     = wr && conf_hit;
   assign ram_we      = wr && !conf_hit;
   assign reg_word    = data_sram.addr[15:2];
   assign ram_idx     = data_sram.addr[RAM_AW+1:2];
   assign irq_clr     = conf_wr && (reg_word == REG_IRQ) && data_sram.wen[0] && data_sram.wdata[0];
   assign unused_addr = ^data_sram.addr[1:0];

   // NOTE: the RAM array has no reset; resetn is in the sensitivity list only so that a
   // write presented while reset is asserted can never commit.
   always_ff @(posedge clk or negedge resetn) begin
      if (resetn && ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram.wen[i]) mem[ram_idx][8*i +: 8] <= data_sram.wdata[8*i +: 8];
         end
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      led_ext              = '0;
      led_ext[LED_W-1:0]   = led_q;
   end

   assign led_merged = lane_merge(led_ext, data_sram.wdata, data_sram.wen);

   always_comb begin
      conf_rdata = '0;
      case (reg_word)
         REG_SCRATCH: conf_rdata = scratch;
         REG_LED:     conf_rdata = led_ext;
         REG_SWITCH:  conf_rdata = {24'b0, switch_sync};
         REG_TIMER:   conf_rdata = timer;
         REG_COMPARE: conf_rdata = compare;
         REG_IRQ:     conf_rdata = {31'b0, irq};
         default:     conf_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         data_sram.rdata <= '0;
      end else if (rd) begin
         data_sram.rdata <= conf_hit ? conf_rdata : mem[ram_idx];
      end
   end

   // Timer and match flag sample their pre-edge values, so a read or compare sees the
   // count held just before the edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         scratch     <= '0;
         led_q       <= '0;
         switch_meta <= '0;
         switch_sync <= '0;
         timer       <= '0;
         compare     <= '1;
         irq         <= 1'b0;
      end else begin
         switch_meta <= switch;
         switch_sync <= switch_meta;
         irq         <= (timer == compare) || (irq && !irq_clr);

         if (conf_wr && reg_word == REG_SCRATCH)
            scratch <= lane_merge(scratch, data_sram.wdata, data_sram.wen);
         if (conf_wr && reg_word == REG_LED)
            led_q <= led_merged[LED_W-1:0];
         if (conf_wr && reg_word == REG_COMPARE)
            compare <= lane_merge(compare, data_sram.wdata, data_sram.wen);

         if (conf_wr && reg_word == REG_TIMER)
            timer <= lane_merge(timer, data_sram.wdata, data_sram.wen);
         else
            timer <= timer + 32'd1;
      end
   end

   assign led       = led_q;
   assign timer_irq = irq;

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Memory-side responder for the CPU's data SRAM port. It accepts the same en/wen/addr/wdata signals the core drives and returns rdata.
- It holds a word-addressed synchronous RAM and a small configuration-register window: scratch, LED, switch, free-running timer, compare and IRQ status.
- It sits at SoC level between the core's data port and board I/O, and replaces an external RAM model for bring-up and test.

Parameters:
RAM_AW, 12, log2 of RAM depth in 32-bit words (default 4096 words = 16 KiB)
CONF_BASE, 32'hBFAF_0000, base of the config-register window; only bits [31:16] are compared
LED_W, 16, width of the LED output register

Ports:
clk  input  1  single clock; all state updates on rising edge
resetn  input  1  asynchronous reset, active low
data_sram_en  input  1  access request this cycle
data_sram_wen  input  4  byte write enables; nonzero = write, zero = read
data_sram_addr  input  32  byte address; bits [1:0] ignored
data_sram_wdata  input  32  write data, lane i = bits [8i+7:8i]
data_sram_rdata  output  32  registered read data
led  output  LED_W  LED register contents
switch  input  8  asynchronous board switches
timer_irq  output  1  timer-match interrupt, level

Behaviour:
- Transaction: occurs on an edge where en=1. Read if wen==4'b0000, write otherwise. en=0 means no effect regardless of wen. There is no stall or handshake; every request completes in one cycle.
- Decode: conf hit = addr[31:16]==CONF_BASE[31:16]. Otherwise RAM, indexed by addr[RAM_AW+1:2]. Upper bits are ignored, so the RAM aliases across the space.
- Read latency is exactly 1 cycle. rdata updates on the edge that samples the read and holds its value on all other cycles, including writes and idle cycles.
- Writes: only lanes with wen[i]=1 are modified; other lanes keep their previous value. This applies to RAM and to writable registers alike.
- Back-to-back accesses: a write at cycle N followed by a read of the same address at N+1 returns the new data. No bypass is needed because the write commits on edge N.
- Register map, offsets from CONF_BASE (addr[15:0]):
  - 0x00 SCRATCH: RW, 32 bits, reset 0.
  - 0x04 LED: RW, low LED_W bits, reset 0. Upper bits read 0.
  - 0x08 SWITCH: RO, {24'b0, switch_sync}. switch passes through a 2-flop synchroniser (reset 0). Writes are ignored.
  - 0x0C TIMER: RW. Increments by 1 every cycle and wraps from 32'hFFFF_FFFF to 0; reset 0. A write loads the lane-merged value, with no increment on that edge. A read returns the value held just before the sampling edge.
  - 0x10 COMPARE: RW, reset 32'hFFFF_FFFF.
  - 0x14 IRQ_STAT: bit0 sticky match flag; other bits read 0.
    - bit0 sets on any edge where the pre-edge TIMER equals COMPARE.
    - Writing wdata[0]=1 with wen[0]=1 clears it.
    - Set and clear on the same edge: set wins.
  - Unmapped offsets read 32'h0; writes to them are ignored.
- timer_irq is IRQ_STAT[0] driven straight from the flop; it is registered and has no combinational path.
- Reset (asynchronous assert, synchronous release): rdata=0, SCRATCH=0, LED=0, TIMER=0, COMPARE=all-ones, IRQ_STAT=0, switch_sync=0.
  - RAM contents are not reset and read X until written.
  - Reset asserted mid-access aborts the access; no partial write may commit.

Test Plan:
- Reset, then read RAM 0x0000_0010 after writing 0xDEADBEEF with wen=4'hF -> rdata=0xDEADBEEF exactly one cycle after the read request; rdata is 0 during reset.
- Full write 0x11223344 to RAM 0x20, then wen=4'b0101 wdata=0xAABBCCDD, then read -> 0x11BB33DD.
- Write LED 0x0000_A5A5, then read 0xBFAF_0004 -> 0x0000A5A5; led=0xA5A5 from the cycle after the write edge. A read at 0xBFAF_0018 -> 0.
- Write TIMER=0xFFFF_FFFE and COMPARE=0x0000_0001 -> TIMER reads wrap 0xFFFF_FFFF, then 0, then 1. timer_irq rises on the edge after TIMER=1. Write IRQ_STAT=1 -> timer_irq falls next edge and stays low until the next match.
- Hold switch=0x3C -> SWITCH reads 0x3C no earlier than 2 edges after the change. Writing 0xFF to SWITCH leaves the read at 0x3C.
- Assert resetn low mid-write to SCRATCH (wen=4'hF, wdata=0x12345678) -> SCRATCH reads 0 after release. Also, a RAM write at addr 0x0001_4000 with RAM_AW=12 aliases to index 0: it reads back at 0x0000_0000.
